// File: rtl/spi_target.sv
// SPI mode-0 responder: oversamples sck/cs/mosi in the clk domain, shifts MOSI
// bytes into a first-word-fallthrough RX FIFO and queued TX bytes onto MISO, MSB first.
module spi_target #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       RX_DEPTH    = 4,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = 8'hFF
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              spi_sck,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [DATA_W-1:0] tx_din,
    input  logic              tx_wr,
    output logic              tx_full,
    output logic [DATA_W-1:0] rx_dout,
    input  logic              rx_rd,
    output logic              rx_data_avail,
    output logic              rx_overflow,
    output logic              busy
);
    localparam int unsigned AW   = $clog2(RX_DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned CW   = $clog2(DATA_W);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_d1_q, cs_d1_q, cs_seen_q;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d1_q;
    assign sck_fall = ~sck_s & sck_d1_q;
    assign cs_rise  = cs_s & ~cs_d1_q;
    assign cs_fall  = ~cs_s & cs_d1_q;

    // cs chain resets low: a cs already low at reset release is never seen as a fresh fall.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_d1_q    <= 1'b0;
            cs_d1_q     <= 1'b0;
            cs_seen_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_d1_q    <= sck_s;
            cs_d1_q     <= cs_s;
            cs_seen_q   <= cs_seen_q | cs_s;
        end
    end

    state_t            state_q;
    logic [CW-1:0]     bit_cnt_q;
    logic [DATA_W-1:0] rx_shift_q, tx_shift_q, hold_q;
    logic              tx_full_q, miso_q, push_q;
    logic              reload;
    logic [DATA_W-1:0] reload_byte;

    assign reload      = (state_q == ST_IDLE) ? cs_fall
                                              : (sck_fall && (bit_cnt_q == '0) && !cs_rise);
    assign reload_byte = tx_full_q ? hold_q : IDLE_FILL;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            hold_q     <= '0;
            tx_full_q  <= 1'b0;
            miso_q     <= 1'b1;
            push_q     <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (reload) begin
                tx_shift_q <= reload_byte;
                miso_q     <= reload_byte[DATA_W-1];
            end
            // A write landing with a reload refills the register the reload just emptied.
            if (tx_wr && (reload || !tx_full_q)) begin
                hold_q    <= tx_din;
                tx_full_q <= 1'b1;
            end else if (reload) begin
                tx_full_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_q <= '0;
                    if (cs_fall) state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= '0;
                        miso_q    <= 1'b1;
                    end else if (sck_rise) begin
                        rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
                        if (bit_cnt_q == CW'(DATA_W - 1)) begin
                            bit_cnt_q <= '0;
                            push_q    <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end else if (sck_fall && (bit_cnt_q != '0)) begin
                        tx_shift_q <= tx_shift_q << 1;
                        miso_q     <= tx_shift_q[DATA_W-2];
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic [DATA_W-1:0] mem_q [RX_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              fifo_full, pop, do_push;

    assign fifo_full = (count_q == CNTW'(RX_DEPTH));
    assign pop       = rx_rd && (count_q != '0);
    assign do_push   = push_q && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: ;
        endcase
        if (pop)                         ovf_d = 1'b0;
        else if (push_q && fifo_full)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            for (int unsigned i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= rx_shift_q;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign spi_miso      = miso_q;
    assign tx_full       = tx_full_q;
    assign rx_data_avail = (count_q != '0);
    assign rx_dout       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign rx_overflow   = ovf_q;
    assign busy          = cs_seen_q & ~cs_s;

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI mode-0 target (responder). Serves as the far end of the `spi_controller` master; used as an on-board peer and a loopback target for the MMIO SPI path.
- Oversamples `spi_sck`, `spi_cs` and `spi_mosi` in the `clk` domain. Deserialises MOSI bytes into an RX FIFO and serialises queued TX bytes onto MISO, MSB first.
- The MMIO-facing side uses the same rd/wr/avail/full strobes as the SPI master.

Parameters:
- DATA_W, 8, bits per SPI frame.
- RX_DEPTH, 4, RX FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2, synchroniser flops on sck/cs/mosi; ≥2.
- IDLE_FILL, 8'hFF, byte shifted out when no TX byte is queued.

Ports:
- clk  in  1  system clock; must run ≥8× the `spi_sck` rate.
- Rst  in  1  reset, asynchronous, active-high.
- spi_sck  in  1  SPI clock from master; idle low.
- spi_cs  in  1  chip select, active low.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  target-out data.
- tx_din  in  DATA_W  byte to send in the next frame.
- tx_wr  in  1  write `tx_din` into the TX holding register.
- tx_full  out  1  TX holding register occupied.
- rx_dout  out  DATA_W  head of RX FIFO (first-word-fallthrough).
- rx_rd  in  1  pop RX FIFO head.
- rx_data_avail  out  1  RX FIFO non-empty.
- rx_overflow  out  1  sticky: a received byte was dropped.
- busy  out  1  `spi_cs` (synchronised) low.

Behaviour:
- Reset values:
  - `spi_miso` = 1, `tx_full` = 0, `rx_dout` = 0, `rx_data_avail` = 0, `rx_overflow` = 0, `busy` = 0.
  - FIFO pointers, bit counter and shift registers are cleared.
- Synchronisation and edge detection:
  - sck, cs and mosi each pass through SYNC_STAGES flops.
  - One further flop on sck and on cs provides edge detection (rise/fall pulses, one `clk` wide).
- Internal states and transitions (DATA_W=8):
  - IDLE: cs high. `spi_miso` = 1, bit_cnt = 0.
  - IDLE → SHIFT on cs fall:
    - tx_shift ← holding register if `tx_full`, else IDLE_FILL; `tx_full` clears.
    - `spi_miso` = tx_shift[7] on the following clk.
  - SHIFT, sck rise: rx_shift ← {rx_shift[6:0], mosi_sync}; bit_cnt++.
  - SHIFT, 8th rise (bit_cnt 7→0):
    - Completed byte is pushed to the RX FIFO on the next clk.
    - `rx_data_avail` rises SYNC_STAGES+2 clk after the pin-level sck rise.
  - SHIFT, sck fall with bit_cnt ≠ 0: tx_shift ← tx_shift<<1, so `spi_miso` presents the next bit.
  - SHIFT, sck fall with bit_cnt = 0 (byte boundary): reload tx_shift from the holding register or IDLE_FILL, with the same clear rule as cs fall.
  - SHIFT → IDLE on cs rise, from any state:
    - Partial RX byte is discarded; bit_cnt = 0; `spi_miso` = 1.
    - A TX byte already loaded into tx_shift is lost; the holding register is untouched.
- TX holding register:
  - `tx_wr` while `tx_full` = 0: load, `tx_full` = 1 next clk.
  - `tx_wr` while `tx_full` = 1: ignored.
  - `tx_wr` in the same clk as a reload: the reload takes the old contents and the new byte lands, so `tx_full` stays 1.
- RX FIFO:
  - `rx_rd` when empty is ignored.
  - Push when full without `rx_rd` in the same clk: byte dropped, `rx_overflow` ← 1.
  - Push when full with `rx_rd` in the same clk: both happen, count unchanged, no overflow.
  - `rx_overflow` clears on any accepted `rx_rd`, or on reset.
  - Pointers wrap modulo RX_DEPTH; count width is log2(RX_DEPTH)+1.
- Reset mid-frame: all state returns to reset values immediately. The frame resumes only after a fresh cs fall.
- Simultaneous sck edge and cs rise in one clk: cs rise wins; the edge is ignored.

Test Plan:
- Load `tx_din` = 8'hA5; master sends 8'h3C → MISO bits observed 1,0,1,0,0,1,0,1; after the frame `rx_dout` = 8'h3C, `rx_data_avail` = 1, `tx_full` = 0.
- No TX queued; master sends 8'h00 → MISO carries 8'hFF; RX FIFO holds 8'h00.
- Five back-to-back bytes 8'h01..8'h05 in one cs window with no reads → FIFO holds 01..04, `rx_overflow` = 1; one `rx_rd` → `rx_dout` = 02, `rx_overflow` = 0.
- cs deasserted after 5 sck rises of 8'hFF → no push, `rx_data_avail` stays 0; next full frame 8'h81 → `rx_dout` = 8'h81.
- FIFO full (4 bytes), `rx_rd` held in the clk the 5th byte pushes → no overflow; count stays 4; tail = 5th byte.
- `Rst` pulsed after 4 sck rises with `tx_full` = 1 → all outputs at reset values (`tx_full` = 0, `spi_miso` = 1) while `Rst` high; next frame sends IDLE_FILL.
